bypass_buff_mp: RTL
===================

Name: bypass_buff_mp

Overview:
- Parametrised write-back bypass buffer for the TPU backend. It sits between the write-back stage and operand read, and is the multi-port successor to the fixed three-source bypass buffer.
- Holds the most recent write-back results in a ring FIFO and forwards the youngest matching value to NUM_SRC source ports, with same-cycle write-back forwarding.
- Adds explicit commit-driven retirement, a flush, overflow detection and an optional registered output stage.

Parameters:
- BUFF_SIZE, 8: number of entries; power of two, at least 2.
- NUM_SRC, 3: number of source read ports, at least 1.
- IDX_WIDTH, 8: register index width.
- DATA_WIDTH, 32: data word width.
- FWD_WB, 1: 1 enables same-cycle forwarding from I_WB_* to the sources.
- OUT_REG, 0: 0 gives combinational outputs; 1 registers O_Src_Data and O_Src_Hit (1-cycle latency).

Ports:
- clock  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Stall  in  1  freezes commit-pop and the output register; stores are still accepted.
- I_Flush  in  1  synchronous clear of all entries.
- I_WB_Valid  in  1  write-back store request.
- I_WB_Index  in  IDX_WIDTH  write-back register index.
- I_WB_Data  in  DATA_WIDTH  write-back data.
- I_Commit  in  1  oldest entry has reached the register file; pop it.
- I_Src_Valid  in  NUM_SRC  per-port lookup valid.
- I_Src_Idx  in  NUM_SRC*IDX_WIDTH  per-port register index, port p at bits [p*IDX_WIDTH +: IDX_WIDTH].
- I_Src_Data  in  NUM_SRC*DATA_WIDTH  register-file read data per port.
- O_Src_Data  out  NUM_SRC*DATA_WIDTH  forwarded or register-file data per port.
- O_Src_Hit  out  NUM_SRC  port p was served from the bypass path.
- O_Full  out  1  all BUFF_SIZE entries valid.
- O_Empty  out  1  no valid entries.
- O_Num  out  $clog2(BUFF_SIZE+1)  valid entry count.
- O_Overflow  out  1  sticky; a store was dropped.

Behaviour:
- Reset (reset=0, asynchronous): all valid bits 0, Wr_Ptr=Rd_Ptr=0, O_Num=0, O_Empty=1, O_Full=0, O_Overflow=0, O_Src_Hit=0, O_Src_Data=0. Buff data and index are not required to reset.
- Storage:
  - Ring of BUFF_SIZE entries {valid, idx, data}.
  - Wr_Ptr and Rd_Ptr are $clog2(BUFF_SIZE) bits and wrap modulo BUFF_SIZE.
  - Count is tracked separately so full and empty are unambiguous.
- Store: when I_WB_Valid=1 and (not full, or a pop occurs in the same cycle), write the entry at Wr_Ptr, set its valid bit, and increment Wr_Ptr.
- Overflow: if full and no pop, drop the store and set O_Overflow (cleared only by reset or I_Flush).
- Pop: a pop occurs when I_Commit=1, I_Stall=0 and the buffer is not empty. It clears valid[Rd_Ptr] and increments Rd_Ptr.
  - I_Commit while empty is ignored.
- Store and pop in the same cycle: both take effect; count is unchanged. When full, the entry being popped frees the slot.
- Lookup, per port p, independent of all other ports:
  - Candidates are valid entries whose idx equals I_Src_Idx[p], gated by I_Src_Valid[p].
  - The youngest candidate is selected, i.e. the one with the smallest (Wr_Ptr-1-i) mod BUFF_SIZE. A re-written index therefore returns the newest value.
  - If FWD_WB=1 and I_WB_Valid=1 and I_WB_Index equals I_Src_Idx[p], I_WB_Data takes priority over the buffer, even if that store is dropped by overflow.
  - On a hit: O_Src_Hit[p]=1 and O_Src_Data[p] is the selected data. On a miss: O_Src_Hit[p]=0 and O_Src_Data[p]=I_Src_Data[p].
  - I_Src_Valid[p]=0 forces a miss and pass-through.
- A pop in the same cycle as a lookup does not hide the popped entry: lookup uses pre-edge state.
- OUT_REG=1: outputs are captured at the clock edge when I_Stall=0 and held while I_Stall=1. Latency is exactly 1 cycle.
- Flush: I_Flush=1 clears all valid bits, both pointers, the count and O_Overflow at the next edge. It has priority over a simultaneous store, pop and overflow (the store is discarded).
- Status outputs:
  - O_Full, O_Empty and O_Num are registered-state derived, with no combinational path from inputs.
  - O_Num = count, with range 0..BUFF_SIZE.
- Reset asserted mid-operation: all state returns to reset values immediately, with no edge needed. Normal operation resumes on the first clock edge after reset deasserts.

Test Plan:
- Store idx 5 data 0xAAAA0001, then idx 5 data 0xAAAA0002; next cycle look up idx 5 on port 0 and idx 6 on port 2. Required: port 0 hit=1 with 0xAAAA0002; port 2 hit=0 passing I_Src_Data.
- FWD_WB=1: with idx 9 in the buffer holding 0x11, present a WB to idx 9 with 0x22 while port 1 looks up idx 9 in the same cycle. Required: O_Src_Data[1]=0x22, hit=1.
- Fill 8 entries (BUFF_SIZE=8): O_Full=1, O_Num=8. A 9th store with no commit: dropped, O_Overflow=1, O_Num=8. Next cycle, store plus I_Commit: accepted, O_Num=8, Rd_Ptr=1, Wr_Ptr=1.
- Commit while I_Stall=1: no pop, O_Num unchanged. Commit on empty: O_Num stays 0, O_Empty=1.
- Wrap-around: perform 20 store/commit pairs on alternating indices, then look up the last index. Required: newest data returned; pointers equal 20 mod 8 = 4.
- I_Flush together with I_WB_Valid: afterwards O_Empty=1, O_Overflow=0, all lookups miss. Assert reset mid-fill: outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/bypass_buff_mp_if.sv
// Bundle of write-back, commit, lookup and status signals for bypass_buff_mp.
// The slave modport is the buffer side; the master modport is whoever drives it.
interface bypass_buff_mp_if #(
  parameter int BUFF_SIZE  = 8,
  parameter int NUM_SRC    = 3,
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_W = $clog2(BUFF_SIZE + 1);

  logic                          I_Stall;
  logic                          I_Flush;
  logic                          I_WB_Valid;
  logic [IDX_WIDTH-1:0]          I_WB_Index;
  logic [DATA_WIDTH-1:0]         I_WB_Data;
  logic                          I_Commit;
  logic [NUM_SRC-1:0]            I_Src_Valid;
  logic [NUM_SRC*IDX_WIDTH-1:0]  I_Src_Idx;
  logic [NUM_SRC*DATA_WIDTH-1:0] I_Src_Data;
  logic [NUM_SRC*DATA_WIDTH-1:0] O_Src_Data;
  logic [NUM_SRC-1:0]            O_Src_Hit;
  logic                          O_Full;
  logic                          O_Empty;
  logic [NUM_W-1:0]              O_Num;
  logic                          O_Overflow;

  modport master (
    output I_Stall, I_Flush, I_WB_Valid, I_WB_Index, I_WB_Data, I_Commit,
           I_Src_Valid, I_Src_Idx, I_Src_Data,
    input  O_Src_Data, O_Src_Hit, O_Full, O_Empty, O_Num, O_Overflow
  );

  modport slave (
    input  I_Stall, I_Flush, I_WB_Valid, I_WB_Index, I_WB_Data, I_Commit,
           I_Src_Valid, I_Src_Idx, I_Src_Data,
    output O_Src_Data, O_Src_Hit, O_Full, O_Empty, O_Num, O_Overflow
  );
endinterface

// File: rtl/bypass_buff_mp.sv
// Multi-port write-back bypass buffer: ring FIFO of recent results, youngest-match
// forwarding to NUM_SRC ports, commit-driven retirement, flush and sticky overflow.
module bypass_buff_mp #(
  parameter int BUFF_SIZE  = 8,
  parameter int NUM_SRC    = 3,
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FWD_WB     = 1,
  parameter int OUT_REG    = 0
) (
  input  logic             clock,
  input  logic             reset,
  bypass_buff_mp_if.slave  bif
);
  localparam int PTR_W = $clog2(BUFF_SIZE);
  localparam int NUM_W = $clog2(BUFF_SIZE + 1);

  logic [BUFF_SIZE-1:0]          valid;
  logic [IDX_WIDTH-1:0]          buf_idx  [BUFF_SIZE];
  logic [DATA_WIDTH-1:0]         buf_data [BUFF_SIZE];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [NUM_W-1:0]              count;
  logic                          overflow;
  logic                          full, empty, pop, push, drop;

  logic [PTR_W-1:0]              pos;
  logic [NUM_SRC-1:0]            lk_hit, out_hit;
  logic [NUM_SRC*DATA_WIDTH-1:0] lk_data, out_data;

  assign full  = (count == NUM_W'(BUFF_SIZE));
  assign empty = (count == '0);
  assign pop   = bif.I_Commit & ~bif.I_Stall & ~empty;
  assign push  = bif.I_WB_Valid & (~full | pop);
  assign drop  = bif.I_WB_Valid & full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bif.I_Flush) begin
      valid    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // When full, pop and push hit the same slot; the later set must win.
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (push && !pop)
        count <= count + NUM_W'(1);
      else if (pop && !push)
        count <= count - NUM_W'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Payload needs no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_idx[wr_ptr]  <= bif.I_WB_Index;
      buf_data[wr_ptr] <= bif.I_WB_Data;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    lk_hit  = '0;
    lk_data = bif.I_Src_Data;
    pos     = '0;
    for (int unsigned p = 0; p < NUM_SRC; p++) begin
      if (bif.I_Src_Valid[p]) begin
        for (int unsigned k = 0; k < BUFF_SIZE; k++) begin
          pos = wr_ptr - PTR_W'(1) - PTR_W'(BUFF_SIZE - 1 - k);
          if (valid[pos] && buf_idx[pos] == bif.I_Src_Idx[p*IDX_WIDTH +: IDX_WIDTH]) begin
            lk_hit[p]                          = 1'b1;
            lk_data[p*DATA_WIDTH +: DATA_WIDTH] = buf_data[pos];
          end
        end
        if ((FWD_WB != 0) && bif.I_WB_Valid &&
            bif.I_WB_Index == bif.I_Src_Idx[p*IDX_WIDTH +: IDX_WIDTH]) begin
          lk_hit[p]                          = 1'b1;
          lk_data[p*DATA_WIDTH +: DATA_WIDTH] = bif.I_WB_Data;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        out_hit  <= '0;
        out_data <= '0;
      end else if (!bif.I_Stall) begin
        out_hit  <= lk_hit;
        out_data <= lk_data;
      end
    end
  end else begin : g_out_comb
    assign out_hit  = lk_hit;
    assign out_data = lk_data;
  end

  assign bif.O_Src_Hit  = out_hit;
  assign bif.O_Src_Data = out_data;
  assign bif.O_Full     = full;
  assign bif.O_Empty    = empty;
  assign bif.O_Num      = count;
  assign bif.O_Overflow = overflow;
endmodule
